mux3_sel_arbiter: RTL

MUX3_SEL_ARBITER -- requirements
Module: mux3_sel_arbiter

---
 rtl/mux3_sel_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/mux3_sel_arbiter.sv
// Round-robin arbiter driving the select of a downstream 3:1 mux.
// Each owner may hold the grant for up to BURST_MAX cycles, and the next owner is handed over without an idle cycle.
module mux3_sel_arbiter #(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned CW        = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] req,
  output logic [1:0] S,
  output logic [2:0] gnt,
  output logic       busy,
  output logic       last
);

  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nx;
  logic [1:0]    owner, owner_nx;
  logic [1:0]    ptr, ptr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    s_nx;
  logic [2:0]    gnt_nx;
  logic          busy_nx;
  logic          last_nx;
  logic          rel;

  // Step a source index modulo 3.
  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : 2'(v + 2'd1);
  endfunction

  // First requester, searching from p upward modulo 3. The caller ensures r != 0.
  function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [2:0] r);
    logic [1:0] i1;
    logic [1:0] i2;
    i1 = inc3(p);
    i2 = inc3(i1);
    if (r[p])       return p;
    else if (r[i1]) return i1;
    else            return i2;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= '0;
      S     <= 2'd0;
      gnt   <= 3'd0;
      busy  <= 1'b0;
      last  <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
      S     <= s_nx;
      gnt   <= gnt_nx;
      busy  <= busy_nx;
      last  <= last_nx;
    end
  end

  // Next state. The output registers are loaded from the next state, so the grant is visible one edge after req is sampled.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    rel      = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx = GRANT;
          owner_nx = rr_pick(ptr, req);
          cnt_nx   = CNT_ONE;
        end
      end
      GRANT: begin
        rel = !req[owner] || (cnt == CNT_MAX);
        if (rel) begin
          ptr_nx = inc3(owner);
          if (|req) begin
            owner_nx = rr_pick(inc3(owner), req);
            cnt_nx   = CNT_ONE;
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    busy_nx = (state_nx == GRANT);
    s_nx    = busy_nx ? owner_nx : 2'd0;
    gnt_nx  = busy_nx ? 3'(3'b001 << owner_nx) : 3'd0;
    last_nx = busy_nx && (cnt_nx == CNT_MAX);
  end

endmodule
